// File: rtl/regfile_ctrl.sv
// regfile_ctrl: write-port controller for the picoMIPS 8-entry register file.
// After reset it sweeps all registers to zero, then arbitrates the single
// write port between core writeback and a host loader, and steers the shared
// address-1 lines between write and read use.

module regfile_ctrl #(
    parameter int n      = 8,
    parameter int STARVE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         core_we,
    input  logic [2:0]   core_waddr,
    input  logic [n-1:0] core_wdata,
    input  logic [2:0]   core_raddr1,
    output logic         core_stall,
    input  logic         host_req,
    input  logic [2:0]   host_waddr,
    input  logic [n-1:0] host_wdata,
    output logic         host_ack,
    output logic         init_busy,
    output logic         rf_write,
    output logic [2:0]   rf_addr1,
    output logic [n-1:0] rf_wdata
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE);
    localparam logic [2:0] LAST_REG   = 3'd7;
    localparam logic [3:0] SCNT_MAX   = 4'hF;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] icnt;
    logic [2:0] icnt_nxt;
    logic [3:0] scnt;
    logic [3:0] scnt_nxt;

    logic       run_active;
    logic       host_win;
    logic       core_win;

    // State, sweep counter and starvation counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            icnt  <= 3'd0;
            scnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            icnt  <= icnt_nxt;
            scnt  <= scnt_nxt;
        end
    end

    // Grant decode: host wins when core is idle or the host has starved long enough
    always_comb begin
        run_active = (state == RUN) && !reset;
        host_win   = run_active && host_req && (!core_we || (scnt >= STARVE_LIM));
        core_win   = run_active && core_we && !host_win;
    end

    // Next-state logic for the sweep and the starvation counter
    always_comb begin
        state_nxt = state;
        icnt_nxt  = icnt;
        scnt_nxt  = scnt;
        case (state)
            INIT: begin
                icnt_nxt = icnt + 3'd1;
                scnt_nxt = 4'd0;
                if (icnt == LAST_REG) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!host_req || host_win) begin
                    scnt_nxt = 4'd0;
                end else if (core_win && (scnt != SCNT_MAX)) begin
                    scnt_nxt = scnt + 4'd1;
                end
            end
            default: begin
                state_nxt = INIT;
                icnt_nxt  = 3'd0;
                scnt_nxt  = 4'd0;
            end
        endcase
    end

    // Output steering; reset forces the sweep outputs so no ack can escape a reset cycle
    always_comb begin
        init_busy  = 1'b0;
        core_stall = 1'b0;
        host_ack   = 1'b0;
        rf_write   = 1'b0;
        rf_addr1   = core_raddr1;
        rf_wdata   = core_wdata;
        if (reset || (state == INIT)) begin
            init_busy  = 1'b1;
            core_stall = 1'b1;
            rf_write   = 1'b1;
            rf_addr1   = reset ? 3'd0 : icnt;
            rf_wdata   = '0;
        end else if (host_win) begin
            host_ack   = 1'b1;
            core_stall = core_we;
            rf_write   = (host_waddr != 3'd0);
            rf_addr1   = host_waddr;
            rf_wdata   = host_wdata;
        end else if (core_win) begin
            rf_write   = (core_waddr != 3'd0);
            rf_addr1   = core_waddr;
            rf_wdata   = core_wdata;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: self-checking bench for regfile_ctrl with a behavioural
// reference model and a simple register file driven by the DUT outputs.

module tb_regfile_ctrl;

    localparam int N      = 8;
    localparam int STARVE = 4;

    logic         clk;
    logic         reset;
    logic         core_we;
    logic [2:0]   core_waddr;
    logic [N-1:0] core_wdata;
    logic [2:0]   core_raddr1;
    logic         core_stall;
    logic         host_req;
    logic [2:0]   host_waddr;
    logic [N-1:0] host_wdata;
    logic         host_ack;
    logic         init_busy;
    logic         rf_write;
    logic [2:0]   rf_addr1;
    logic [N-1:0] rf_wdata;

    int checks;
    int errors;

    // Reference model state: sweep cycles left, host losses, expected registers
    int           m_init_left;
    int           m_lost;
    logic [N-1:0] exp_mem [8];
    logic [N-1:0] rf_mem  [8];

    logic [14:0]  exp_v;
    logic [14:0]  obs_v;

    regfile_ctrl #(.n(N), .STARVE(STARVE)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_we    (core_we),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .core_raddr1(core_raddr1),
        .core_stall (core_stall),
        .host_req   (host_req),
        .host_waddr (host_waddr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .init_busy  (init_busy),
        .rf_write   (rf_write),
        .rf_addr1   (rf_addr1),
        .rf_wdata   (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the DUT's write port
    always @(posedge clk) begin
        if (rf_write) rf_mem[rf_addr1] <= rf_wdata;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata}
    function automatic logic [14:0] model_expect();
        logic hw;
        logic cw;
        if (reset) return {1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};
        if (m_init_left > 0) return {1'b1, 1'b1, 1'b0, 1'b1, 3'(8 - m_init_left), 8'h00};
        hw = host_req && (!core_we || (m_lost >= STARVE));
        cw = core_we && !hw;
        if (hw) return {1'b0, core_we, 1'b1, (host_waddr != 3'd0), host_waddr, host_wdata};
        if (cw) return {1'b0, 1'b0, 1'b0, (core_waddr != 3'd0), core_waddr, core_wdata};
        return {1'b0, 1'b0, 1'b0, 1'b0, core_raddr1, core_wdata};
    endfunction

    // Advance the model across one rising edge using the current inputs
    task automatic model_advance();
        logic hw;
        logic cw;
        if (reset) begin
            m_init_left = 8;
            m_lost      = 0;
            exp_mem[0]  = 8'h00;
        end else if (m_init_left > 0) begin
            exp_mem[8 - m_init_left] = 8'h00;
            m_init_left = m_init_left - 1;
            m_lost      = 0;
        end else begin
            hw = host_req && (!core_we || (m_lost >= STARVE));
            cw = core_we && !hw;
            if (hw) begin
                if (host_waddr != 3'd0) exp_mem[host_waddr] = host_wdata;
                m_lost = 0;
            end else if (cw) begin
                if (core_waddr != 3'd0) exp_mem[core_waddr] = core_wdata;
                if (host_req && m_lost < 15) m_lost = m_lost + 1;
            end
            if (!host_req) m_lost = 0;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic cwe, input logic [2:0] cwa,
                                 input logic [7:0] cwd, input logic [2:0] cra, input logic hreq,
                                 input logic [2:0] hwa, input logic [7:0] hwd);
        reset       = rst;
        core_we     = cwe;
        core_waddr  = cwa;
        core_wdata  = cwd;
        core_raddr1 = cra;
        host_req    = hreq;
        host_waddr  = hwa;
        host_wdata  = hwd;
    endtask

    task automatic advance_cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 11; c++) begin
            applyStimulus(c < 2, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00);
            @(negedge clk);
            exp_v = model_expect();
            obs_v = {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL reset_sweep cycle %0d: got %h required %h", c, obs_v, exp_v);
            end
            advance_cycle();
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf_mem[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_readback r%0d: got %h required 00", i, rf_mem[i]);
            end
        end
    endtask

    task automatic test_core_write();
        applyStimulus(1'b0, 1'b1, 3'd3, 8'h5A, 3'd0, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        exp_v = model_expect();
        obs_v = {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL core_write: got %h required %h", obs_v, exp_v);
        end
        advance_cycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        exp_v = model_expect();
        obs_v = {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL core_idle_read: got %h required %h", obs_v, exp_v);
        end
        checks++;
        if (rf_mem[3] !== exp_mem[3]) begin
            errors++;
            $display("[TB] FAIL core_write_r3: got %h required %h", rf_mem[3], exp_mem[3]);
        end
        advance_cycle();
    endtask

    task automatic test_starvation();
        int ack_at;
        ack_at = 0;
        for (int c = 1; c <= STARVE + 3 && ack_at == 0; c++) begin
            applyStimulus(1'b0, 1'b1, 3'($urandom_range(1, 4)), 8'($urandom), 3'd0, 1'b1, 3'd5, 8'hC3);
            @(negedge clk);
            exp_v = model_expect();
            obs_v = {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL starve_cycle %0d: got %h required %h", c, obs_v, exp_v);
            end
            if (host_ack === 1'b1) ack_at = c;
            advance_cycle();
        end
        checks++;
        if (ack_at != STARVE + 1) begin
            errors++;
            $display("[TB] FAIL starve_ack_cycle: got %0d required %0d", ack_at, STARVE + 1);
        end
        // New request right after the ack must start from a cleared count
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, (c == 0), 3'd2, 8'h44, 3'd0, 1'b1, 3'd6, 8'h6E);
            @(negedge clk);
            exp_v = model_expect();
            obs_v = {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL starve_followup %0d: got %h required %h", c, obs_v, exp_v);
            end
            advance_cycle();
        end
        checks++;
        if (rf_mem[5] !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL starve_r5: got %h required c3", rf_mem[5]);
        end
    endtask

    task automatic test_addr0();
        applyStimulus(1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        exp_v = model_expect();
        obs_v = {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL addr0_write: got %h required %h", obs_v, exp_v);
        end
        advance_cycle();
        checks++;
        if (rf_mem[0] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL addr0_r0: got %h required 00", rf_mem[0]);
        end
    endtask

    task automatic test_host_during_init();
        int ack_at;
        ack_at = -1;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(c == 0, 1'b0, 3'd0, 8'h00, 3'd0, c >= 3, 3'd2, 8'h9C);
            @(negedge clk);
            exp_v = model_expect();
            obs_v = {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL init_host cycle %0d: got %h required %h", c, obs_v, exp_v);
            end
            if (host_ack === 1'b1 && ack_at < 0) ack_at = c;
            advance_cycle();
        end
        checks++;
        if (ack_at != 9) begin
            errors++;
            $display("[TB] FAIL init_host_ack_cycle: got %0d required 9", ack_at);
        end
        checks++;
        if (rf_mem[2] !== 8'h9C) begin
            errors++;
            $display("[TB] FAIL init_host_r2: got %h required 9c", rf_mem[2]);
        end
    endtask

    task automatic test_reset_midflight();
        logic ack_seen;
        ack_seen = 1'b0;
        for (int c = 0; c < 17; c++) begin
            if (c == 0)      applyStimulus(1'b0, 1'b1, 3'd3, 8'h11, 3'd0, 1'b0, 3'd0, 8'h00);
            else if (c == 1) applyStimulus(1'b0, 1'b1, 3'd5, 8'h22, 3'd0, 1'b0, 3'd0, 8'h00);
            else if (c < 7)  applyStimulus(c == 6, 1'b1, 3'd1, 8'($urandom), 3'd0, 1'b1, 3'd5, 8'hC3);
            else             applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00);
            @(negedge clk);
            exp_v = model_expect();
            obs_v = {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL midflight cycle %0d: got %h required %h", c, obs_v, exp_v);
            end
            if (c >= 2 && c < 7 && host_ack !== 1'b0) ack_seen = 1'b1;
            advance_cycle();
        end
        checks++;
        if (ack_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midflight_no_ack: got %b required 0", ack_seen);
        end
        checks++;
        if (rf_mem[3] !== 8'h00 || rf_mem[5] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midflight_rezero: got r3=%h r5=%h required 00/00", rf_mem[3], rf_mem[5]);
        end
    endtask

    task automatic test_random();
        logic       pending;
        logic [2:0] h_a;
        logic [7:0] h_d;
        pending = 1'b0;
        h_a     = 3'd0;
        h_d     = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if (!pending && $urandom_range(0, 2) == 0) begin
                pending = 1'b1;
                h_a     = 3'($urandom);
                h_d     = 8'($urandom);
            end
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 3'($urandom),
                          8'($urandom), 3'($urandom), pending, h_a, h_d);
            @(negedge clk);
            exp_v = model_expect();
            obs_v = {init_busy, core_stall, host_ack, rf_write, rf_addr1, rf_wdata};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h required %h", c, obs_v, exp_v);
            end
            if (exp_v[12]) pending = 1'b0;
            advance_cycle();
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf_mem[i] !== exp_mem[i]) begin
                errors++;
                $display("[TB] FAIL random_readback r%0d: got %h required %h", i, rf_mem[i], exp_mem[i]);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        m_init_left = 8;
        m_lost      = 0;
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00);
        @(posedge clk);
        #1;
        test_reset();
        test_core_write();
        test_starvation();
        test_addr0();
        test_host_during_init();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
